if_fetch_unit: RTL and testbench

Instruction-fetch stage that directly feeds the IF/ID pipeline register. It owns the fetch PC and drives a one-outstanding-request instruction-memory handshake with variable read latency. A 2-entry output buffer absorbs responses while downstream is stalled. It handles redirects from branches and jumps, including squashing an in-flight response.

---
 rtl/if_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight, buffers two responses.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_CHK_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_original,
  output logic [31:0] pc_inc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        outstanding_q, outstanding_d;
  logic [1:0]  count_q, count_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [31:0] redir_target;
  logic        redir_bad;
  logic        push, pop, issue, wr_idx;
  logic [1:0]  count_after;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_target     = redirect_pc;
  assign redir_bad        = redirect_pc[1:0] != 2'b00;
  assign fetch_misaligned = misaligned_q;
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_target         = {redirect_pc[31:2], 2'b00};
  assign redir_bad            = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_addr_d    = req_addr_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    misaligned_d  = misaligned_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    push          = 1'b0;
    pop           = 1'b0;
    issue         = 1'b0;
    wr_idx        = 1'b0;
    count_after   = count_q;

    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        push        = imem_rvalid && outstanding_q && !redirect_valid;
        pop         = pc_write && (count_q != 2'd0) && !redirect_valid;
        count_after = count_q - {1'b0, pop} + {1'b0, push};
        // Issue only when the response is guaranteed a free slot in the buffer.
        issue       = (!outstanding_q || imem_rvalid) && (count_after <= 2'd1) &&
                      !redirect_valid && !misaligned_q;
        count_d     = count_after;
        if (imem_rvalid && outstanding_q) outstanding_d = 1'b0;
        if (redirect_valid && outstanding_q && !imem_rvalid) state_d = DRAIN;
      end
      DRAIN: begin
        if (imem_rvalid) begin
          outstanding_d = 1'b0;
          state_d       = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      buf_instr_d[0] = buf_instr_q[1];
      buf_pc_d[0]    = buf_pc_q[1];
    end
    wr_idx = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);
    if (push) begin
      buf_instr_d[wr_idx] = imem_rdata;
      buf_pc_d[wr_idx]    = req_addr_q;
    end

    if (redirect_valid) begin
      count_d    = 2'd0;
      fetch_pc_d = redir_target;
      if (redir_bad) misaligned_d = 1'b1;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      req_addr_d    = fetch_pc_q;
      outstanding_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      count_q       <= 2'd0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // Payload registers carry no reset; the head is masked by count_q.
  always_ff @(posedge clk) begin
    req_addr_q  <= req_addr_d;
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

  assign imem_req    = issue & reset;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = count_q != 2'd0;
  assign instr       = instr_valid ? buf_instr_q[0] : NOP_INSTR;
  assign pc_original = instr_valid ? buf_pc_q[0] : 32'd0;
  assign pc_inc      = instr_valid ? buf_pc_q[0] + 32'd4 : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle table, reset/wrap sequences and a randomized run
// against a program-order reference model with a variable-latency memory.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, pc_write, redirect_valid, imem_req, imem_rvalid, instr_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, pc_original, pc_inc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk),
    .reset(reset),
    .pc_write(pc_write),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .pc_original(pc_original),
    .pc_inc(pc_inc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  typedef struct {
    int          rst_n, pw, rd;
    logic [31:0] rpc;
    int          lat;
    int          e_req;
    logic [31:0] e_addr;
    int          e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  // memory model: one pending response, countdown to rvalid
  bit          mem_busy, mem_stale;
  int          mem_cnt;
  logic [31:0] mem_addr;
  // reference model: expected next request address and next accepted PC
  bit          model_en, after_redir, after_reset;
  logic [31:0] exp_req, exp_pop;
  int          pops;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] rpc);
`ifdef FETCH_MISALIGN_CHK_EN
    return rpc;
`else
    return rpc & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic void add(input int rn, input int pw, input int rd, input logic [31:0] rpc,
                              input int lat, input int er, input logic [31:0] ea,
                              input int ev, input logic [31:0] ep);
    vec_t v;
    v.rst_n = rn; v.pw = pw; v.rd = rd; v.rpc = rpc; v.lat = lat;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_pc = ep;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_check(input logic rst_n, input logic pw, input logic rd,
                             input logic [31:0] rpc);
    if (after_reset) begin
      chkb("rst_req", imem_req, 1'b0);
      chkb("rst_vld", instr_valid, 1'b0);
      chk("rst_instr", instr, NOP_INSTR);
      chk("rst_pc", pc_original, 32'd0);
      chk("rst_pcinc", pc_inc, 32'd0);
    end
    if (!rst_n) begin
      exp_req     = RESET_PC;
      exp_pop     = RESET_PC;
      after_reset = 1'b1;
      after_redir = 1'b0;
    end else begin
      if (after_redir) chkb("flush_vld", instr_valid, 1'b0);
      if (instr_valid) begin
        chk("head_instr", instr, memf(pc_original));
        chk("head_pcinc", pc_inc, pc_original + 32'd4);
      end else begin
        chk("empty_instr", instr, NOP_INSTR);
        chk("empty_pc", pc_original, 32'd0);
        chk("empty_pcinc", pc_inc, 32'd0);
      end
      if (imem_req) begin
        chk("req_addr", imem_addr, exp_req);
        chkb("req_during_redirect", rd, 1'b0);
        chkb("second_outstanding", mem_busy && !mem_stale && !imem_rvalid, 1'b0);
        exp_req = exp_req + 32'd4;
      end
      if (pw && !rd && instr_valid) begin
        chk("pop_pc", pc_original, exp_pop);
        exp_pop = exp_pop + 32'd4;
        pops++;
      end
      if (rd) begin
        exp_req = tgt(rpc);
        exp_pop = tgt(rpc);
      end
      after_redir = rd;
      after_reset = 1'b0;
    end
  endtask

  task automatic cycle(input logic rst_n, input logic pw, input logic rd, input logic [31:0] rpc,
                       input int lat, output logic s_req, output logic [31:0] s_addr,
                       output logic s_vld, output logic [31:0] s_pc);
    reset = rst_n; pc_write = pw; redirect_valid = rd; redirect_pc = rpc;
    if (mem_busy && mem_cnt == 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_vld = instr_valid; s_pc = pc_original;
    if (model_en) model_check(rst_n, pw, rd, rpc);
    @(posedge clk);
    #1;
    if (imem_rvalid) begin
      mem_busy  = 1'b0;
      mem_stale = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
    end
    if (!rst_n) mem_stale = mem_busy;
    if (s_req) begin
      mem_busy = 1'b1; mem_stale = 1'b0; mem_cnt = lat; mem_addr = s_addr;
    end
  endtask

  initial begin
    logic        s_req, s_vld;
    logic [31:0] s_addr, s_pc;
    reset = 1'b0; pc_write = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    mem_busy = 1'b0; mem_stale = 1'b0; mem_cnt = 0; mem_addr = '0;
    model_en = 1'b0; after_redir = 1'b0; after_reset = 1'b0;
    exp_req = RESET_PC; exp_pop = RESET_PC; pops = 0;

    // rst_n pw rd rpc lat | req addr vld pc
    add(1,1,0,0,1, 0,0,0,0);
    add(1,1,0,0,1, 1,0,0,0);
    add(1,1,0,0,1, 1,4,0,0);
    add(1,1,0,0,1, 1,8,1,0);
    add(1,1,0,0,1, 1,12,1,4);
    for (int i = 0; i < 5; i++) add(1,0,0,0,1, 0,0,1,8);
    add(1,1,0,0,1, 1,16,1,8);
    add(1,1,0,0,1, 1,20,1,12);
    add(1,1,0,0,1, 1,24,1,16);
    add(1,1,0,0,3, 1,28,1,20);
    add(1,1,0,0,1, 0,0,1,24);
    add(1,1,1,32'h100,1, 0,0,0,0);
    add(1,1,0,0,1, 0,0,0,0);
    add(1,1,0,0,1, 1,32'h100,0,0);
    add(1,1,0,0,1, 1,32'h104,0,0);
    add(1,1,1,32'h200,1, 0,0,1,32'h100);
    add(1,1,0,0,1, 1,32'h200,0,0);
    add(1,1,0,0,1, 1,32'h204,0,0);
    add(1,1,0,0,1, 1,32'h208,1,32'h200);

    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    model_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
`ifdef FETCH_MISALIGN_CHK_EN
    chkb("misaligned_after_reset", fetch_misaligned, 1'b0);
`endif

    foreach (tbl[i]) begin
      cycle(tbl[i].rst_n != 0, tbl[i].pw != 0, tbl[i].rd != 0, tbl[i].rpc, tbl[i].lat,
            s_req, s_addr, s_vld, s_pc);
      chkb($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req != 0);
      if (tbl[i].e_req != 0) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
      chkb($sformatf("tbl%0d_vld", i), s_vld, tbl[i].e_vld != 0);
      if (tbl[i].e_vld != 0) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
    end

    // Reset while a 3-cycle request is in flight; its late response lands in IDLE.
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 3, s_req, s_addr, s_vld, s_pc);
    chkb("inflight_req", s_req, 1'b1);
    chk("inflight_addr", s_addr, 32'h20C);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    chkb("midreset_req", s_req, 1'b0);
    chkb("midreset_vld", s_vld, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    chkb("idle_req", s_req, 1'b0);
    chkb("late_rvalid_ignored", s_vld, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    chkb("restart_req", s_req, 1'b1);
    chk("restart_addr", s_addr, RESET_PC);
    chkb("restart_vld", s_vld, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    chkb("restart_vld2", s_vld, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    chkb("restart_head_vld", s_vld, 1'b1);
    chk("restart_head_pc", s_pc, RESET_PC);

    // Fetch PC wraps from 0xFFFF_FFFC to 0.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1, s_req, s_addr, s_vld, s_pc);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    chk("wrap_addr1", s_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    chk("wrap_addr2", s_addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);

    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rn, pw, rd;
      logic [31:0] rpc;
      rn  = $urandom_range(0, 299) != 0;
      pw  = $urandom_range(0, 9) < 7;
      rd  = $urandom_range(0, 19) == 0;
      rpc = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
      rpc[1:0] = 2'b00;
`endif
      cycle(rn, pw, rd, rpc, $urandom_range(1, 4), s_req, s_addr, s_vld, s_pc);
    end
    chkb("random_progress", pops > 200, 1'b1);

`ifdef FETCH_MISALIGN_CHK_EN
    cycle(1'b1, 1'b1, 1'b1, 32'h102, 1, s_req, s_addr, s_vld, s_pc);
    chkb("misaligned_set", fetch_misaligned, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
      chkb("misaligned_no_req", s_req, 1'b0);
      chkb("misaligned_sticky", fetch_misaligned, 1'b1);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1, s_req, s_addr, s_vld, s_pc);
    chkb("misaligned_cleared", fetch_misaligned, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
